// File: rtl/multi_channel_glitch_filter_pkg.sv
// Shared defaults and helpers for the multi-channel glitch filter.
// Imported by the interface, the channel slice and the top level.
package multi_channel_glitch_filter_pkg;

    localparam int CH_DEF   = 4;
    localparam int CNT_DEF  = 4;
    localparam int SYNC_DEF = 2;

    // Width of the stability counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/multi_channel_glitch_filter_if.sv
// Signal bundle between the raw-input side and the glitch filter.
// master drives inputs and reads results; slave is the filter.
interface multi_channel_glitch_filter_if
    import multi_channel_glitch_filter_pkg::*;
#(
    parameter int CH = CH_DEF
);

    logic [CH-1:0] din;
    logic [CH-1:0] en;
    logic          clr_glitch;
    logic [CH-1:0] dout;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] glitch;
    logic          glitch_any;

    modport master (
        output din,
        output en,
        output clr_glitch,
        input  dout,
        input  rise,
        input  fall,
        input  glitch,
        input  glitch_any
    );

    modport slave (
        input  din,
        input  en,
        input  clr_glitch,
        output dout,
        output rise,
        output fall,
        output glitch,
        output glitch_any
    );

endinterface

// File: rtl/multi_channel_glitch_filter_channel.sv
// One filter slice: synchroniser, stability counter, filtered level,
// edge strobes and sticky glitch flag.
module glitch_filter_channel
    import multi_channel_glitch_filter_pkg::*;
#(
    parameter int   CNT     = CNT_DEF,
    parameter int   SYNC    = SYNC_DEF,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    input  logic i_en,
    input  logic i_clr,
    output logic o_dout,
    output logic o_rise,
    output logic o_fall,
    output logic o_glitch
);

    localparam int            CW   = cnt_width(CNT);
    localparam logic [CW-1:0] CMAX = CW'(CNT - 1);

    logic [SYNC-1:0] r_sync;
    logic [CW-1:0]   r_cnt;
    logic            r_dout;
    logic            r_rise;
    logic            r_fall;
    logic            r_glitch;

    logic [CW-1:0]   w_cnt_nxt;
    logic            w_dout_nxt;
    logic            w_glitch_set;
    logic            w_s;
    logic            w_same;
    logic            w_last;

    assign w_s    = r_sync[SYNC-1];
    assign w_same = (w_s == r_dout);
    assign w_last = (r_cnt == CMAX);

    // Counter only survives while the synchronised level differs from dout.
    always_comb begin
        w_cnt_nxt    = '0;
        w_dout_nxt   = r_dout;
        w_glitch_set = 1'b0;
        unique case (1'b1)
            !i_en: begin
                w_dout_nxt = w_s;
            end
            (i_en && w_same): begin
                w_glitch_set = (r_cnt != '0);
            end
            (i_en && !w_same && w_last): begin
                w_dout_nxt = w_s;
            end
            default: begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= {SYNC{RST_VAL}};
            r_cnt    <= '0;
            r_dout   <= RST_VAL;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_glitch <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC-2:0], i_din};
            r_cnt    <= w_cnt_nxt;
            r_dout   <= w_dout_nxt;
            r_rise   <= w_dout_nxt & ~r_dout;
            r_fall   <= ~w_dout_nxt & r_dout;
            // A new rejection outranks a simultaneous clear.
            r_glitch <= w_glitch_set | (r_glitch & ~i_clr);
        end
    end

    assign o_dout   = r_dout;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_glitch = r_glitch;

endmodule

// File: rtl/multi_channel_glitch_filter.sv
// CH independent glitch-filter slices with a shared glitch clear
// and a combined glitch indicator.
module multi_channel_glitch_filter
    import multi_channel_glitch_filter_pkg::*;
#(
    parameter int   CH      = CH_DEF,
    parameter int   CNT     = CNT_DEF,
    parameter int   SYNC    = SYNC_DEF,
    parameter logic RST_VAL = 1'b0
) (
    input logic                          clk,
    input logic                          rst_n,
    multi_channel_glitch_filter_if.slave bus
);

    logic [CH-1:0] w_dout;
    logic [CH-1:0] w_rise;
    logic [CH-1:0] w_fall;
    logic [CH-1:0] w_glitch;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        glitch_filter_channel #(
            .CNT     (CNT),
            .SYNC    (SYNC),
            .RST_VAL (RST_VAL)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_din    (bus.din[g]),
            .i_en     (bus.en[g]),
            .i_clr    (bus.clr_glitch),
            .o_dout   (w_dout[g]),
            .o_rise   (w_rise[g]),
            .o_fall   (w_fall[g]),
            .o_glitch (w_glitch[g])
        );
    end

    assign bus.dout       = w_dout;
    assign bus.rise       = w_rise;
    assign bus.fall       = w_fall;
    assign bus.glitch     = w_glitch;
    assign bus.glitch_any = |w_glitch;

endmodule

// File: tb/tb_multi_channel_glitch_filter.sv
// Directed bench for the multi-channel glitch filter (CH=4, CNT=4,
// SYNC=2): per-edge vector table plus hand-written reset sequences.
module tb_multi_channel_glitch_filter;

    typedef struct {
        logic [3:0] din;
        logic [3:0] en;
        logic       clr;
        logic [3:0] dout;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] glitch;
        logic       gany;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    vec_t tv[$];

    multi_channel_glitch_filter_if #(.CH(4)) bus ();

    multi_channel_glitch_filter #(
        .CH      (4),
        .CNT     (4),
        .SYNC    (2),
        .RST_VAL (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string      name,
        input logic [3:0] d,
        input logic [3:0] r,
        input logic [3:0] f,
        input logic [3:0] g,
        input logic       ga
    );
        n_checks++;
        if (bus.dout !== d || bus.rise !== r || bus.fall !== f ||
            bus.glitch !== g || bus.glitch_any !== ga) begin
            n_errors++;
            $display("FAIL %s: got dout=%b rise=%b fall=%b glitch=%b any=%b, want %b %b %b %b %b",
                     name, bus.dout, bus.rise, bus.fall, bus.glitch,
                     bus.glitch_any, d, r, f, g, ga);
        end
    endtask

    task automatic add(
        input logic [3:0] din,
        input logic [3:0] en,
        input logic       clr,
        input logic [3:0] dout,
        input logic [3:0] rise,
        input logic [3:0] fall,
        input logic [3:0] glitch,
        input logic       gany
    );
        vec_t v;
        v.din = din; v.en = en; v.clr = clr;
        v.dout = dout; v.rise = rise; v.fall = fall;
        v.glitch = glitch; v.gany = gany;
        tv.push_back(v);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // ch0 held high from edge 0; ch1 high for 3 edges (rejected)
        add(4'b0011, 4'hF, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0); // 0
        add(4'b0011, 4'hF, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0); // 1
        add(4'b0011, 4'hF, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0); // 2
        add(4'b0001, 4'hF, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0); // 3
        add(4'b0001, 4'hF, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0); // 4
        add(4'b0001, 4'hF, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 1); // 5
        add(4'b0001, 4'hF, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 1); // 6
        add(4'b0001, 4'hF, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0); // 7
        add(4'b0001, 4'hF, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0); // 8
        add(4'b0001, 4'hF, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0); // 9
        // ch2 high for exactly 4 edges (accepted, minimum pulse)
        add(4'b0101, 4'hF, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0); // 10
        add(4'b0101, 4'hF, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0); // 11
        add(4'b0101, 4'hF, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0); // 12
        add(4'b0101, 4'hF, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0); // 13
        add(4'b0001, 4'hF, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0); // 14
        add(4'b0001, 4'hF, 0, 4'b0101, 4'b0100, 4'b0000, 4'b0000, 0); // 15
        add(4'b0001, 4'hF, 0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 0); // 16
        add(4'b0001, 4'hF, 0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 0); // 17
        add(4'b0001, 4'hF, 0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 0); // 18
        add(4'b0001, 4'hF, 0, 4'b0001, 4'b0000, 4'b0100, 4'b0000, 0); // 19
        add(4'b0001, 4'hF, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0); // 20
        // ch3 bypass, 1-edge pulse
        add(4'b0001, 4'h7, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0); // 21
        add(4'b1001, 4'h7, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0); // 22
        add(4'b0001, 4'h7, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0); // 23
        add(4'b0001, 4'h7, 0, 4'b1001, 4'b1000, 4'b0000, 4'b0000, 0); // 24
        add(4'b0001, 4'h7, 0, 4'b0001, 4'b0000, 4'b1000, 4'b0000, 0); // 25
        add(4'b0001, 4'h7, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0); // 26
        // ch1 2-edge pulse; clear on the rejecting edge loses
        add(4'b0001, 4'h7, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0); // 27
        add(4'b0011, 4'h7, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0); // 28
        add(4'b0011, 4'h7, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0); // 29
        add(4'b0001, 4'h7, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0); // 30
        add(4'b0001, 4'h7, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0); // 31
        add(4'b0001, 4'h7, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 1); // 32
        add(4'b0001, 4'h7, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 1); // 33
        add(4'b0001, 4'h7, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0); // 34
        add(4'b0001, 4'h7, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0); // 35

        bus.din        = 4'b0000;
        bus.en         = 4'hF;
        bus.clr_glitch = 1'b0;
        rst_n          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            bus.din        = tv[i].din;
            bus.en         = tv[i].en;
            bus.clr_glitch = tv[i].clr;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), tv[i].dout, tv[i].rise,
                  tv[i].fall, tv[i].glitch, tv[i].gany);
        end

        // ch0 starts counting toward a fall, then reset hits mid-count
        bus.din        = 4'b0000;
        bus.en         = 4'hF;
        bus.clr_glitch = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("precnt%0d", i), 4'b0001, 4'b0000,
                  4'b0000, 4'b0000, 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        check("rst_hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("postrst%0d", i), 4'b0000, 4'b0000,
                  4'b0000, 4'b0000, 1'b0);
        end

        // ch0 high for 2 edges, reset before acceptance
        bus.din = 4'b0001;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        bus.din = 4'b0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("quiet%0d", i), 4'b0000, 4'b0000,
                  4'b0000, 4'b0000, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
